vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 SHALL have parameter H_BACK, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_VISIBLE, default 480, visible lines per frame.
REQ-006 SHALL have parameter V_FRONT, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 SHALL have parameter V_BACK, default 33, vertical back porch in lines.
REQ-009 SHALL have port vga_clk, input, 1, sole clock, rising edge.
REQ-010 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-011 SHALL have port pix_en, input, 1, pixel-advance enable; the timing state advances only on cycles where pix_en=1.
REQ-012 SHALL have port DrawX, output, 10, current pixel column.
REQ-013 SHALL have port DrawY, output, 10, current pixel line.
REQ-014 SHALL have port hs, output, 1, horizontal sync, active-low.
REQ-015 SHALL have port vs, output, 1, vertical sync, active-low.
REQ-016 SHALL have port blank, output, 1, 1 = visible region, 0 = blanking.
REQ-017 SHALL have port frame_start, output, 1, one-vga_clk pulse at the start of a frame.
REQ-018 SHALL have port frame_count, output, 16, count of completed frames.

Function
REQ-019 SHALL define H_TOTAL = sum of the H_* parameters (800 by default) and V_TOTAL = sum of the V_* parameters (525 by default).
REQ-020 SHALL increment DrawX on each pix_en cycle, and SHALL wrap DrawX from H_TOTAL-1 to 0.
REQ-021 SHALL increment DrawY only in the cycle where DrawX wraps, and SHALL wrap DrawY from V_TOTAL-1 to 0 in that same cycle.
REQ-022 SHALL hold every register unchanged, including all delay stages, on cycles where pix_en=0.
REQ-023 SHALL register hs, vs and blank from the next-state counter values, so that they are cycle-aligned with DrawX/DrawY when VGA_SYNC_DELAY_EN is undefined.
REQ-024 SHALL drive hs=0 iff DrawX is in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], which is [656,751] by default.
REQ-025 SHALL drive vs=0 iff DrawY is in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1], which is [490,491] by default.
REQ-026 SHALL drive blank=1 iff DrawX<H_VISIBLE and DrawY<V_VISIBLE.
REQ-027 SHALL assert frame_start for exactly one vga_clk cycle, namely the cycle in which (DrawX,DrawY) transitions from (H_TOTAL-1,V_TOTAL-1) to (0,0).
REQ-028 SHALL increment frame_count in that same transition cycle, and SHALL wrap frame_count from 65535 to 0.
REQ-029 SHALL make all outputs register outputs, with no combinational path from pix_en to any output.
REQ-030 SHALL keep frame_start low on a pix_en=0 cycle, even when the counters are at (799,524).

Reset
REQ-031 SHALL, while reset_n=0, asynchronously force DrawX=0, DrawY=0, hs=1, vs=1, blank=0, frame_start=0 and frame_count=0, and SHALL clear all delay stages to hs=1, vs=1, blank=0.
REQ-032 SHALL restart timing from (0,0) when reset_n is asserted mid-frame, and SHALL NOT produce a frame_start pulse for the aborted frame.
REQ-033 SHALL produce DrawX=1 on the first pix_en cycle after reset_n deasserts, with blank=1 in that same cycle.

Configuration
REQ-034 SHALL compile in, when macro VGA_SYNC_DELAY_EN is defined, a 2-stage pix_en-qualified delay on hs, vs and blank, so that these lag DrawX/DrawY by two pixel advances to match the sprite-ROM plus color-mapping latency; DrawX, DrawY, frame_start and frame_count are not delayed.
REQ-035 SHALL, when VGA_SYNC_DELAY_EN is undefined, contain no delay stages, with hs, vs and blank aligned with DrawX/DrawY per REQ-023.

Verification
REQ-036 SHALL cover: pix_en=1 continuously after reset -> hs low for exactly 96 consecutive cycles starting when DrawX=656; line period is 800 cycles.
REQ-037 SHALL cover: pix_en=1 continuously -> vs low for exactly 1600 cycles (DrawY 490-491); frame period is 420000 cycles; frame_start pulses once per frame; frame_count reaches 2 after two frames.
REQ-038 SHALL cover: pix_en toggling 1,0,1,0 -> counters advance every other cycle; line period is 1600 vga_clk cycles; frame_start width is 1 cycle.
REQ-039 SHALL cover: reset_n pulsed low at DrawX=300, DrawY=200 -> outputs take their reset values immediately, without waiting for a clock edge; after release, DrawX=1 and DrawY=0 on the next pix_en cycle; no frame_start pulse occurs.
REQ-040 SHALL cover: VGA_SYNC_DELAY_EN defined -> blank falls two pix_en cycles after DrawX goes from 639 to 640; hs falls two pix_en cycles after DrawX reaches 656.
REQ-041 SHALL cover: frame_count forced near wrap by running 65536 frames (or via a bind/force in the bench) -> frame_count goes from 65535 to 0 at the frame_start pulse.

Source files
------------

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator (optional sync delay: VGA_SYNC_DELAY_EN)
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  input  logic        pix_en,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        hs,
  output logic        vs,
  output logic        blank,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [9:0] x_next;
  logic [9:0] y_next;
  logic       x_wrap;
  logic       y_wrap;
  logic       frame_wrap;
  logic       hs_next;
  logic       vs_next;
  logic       blank_next;

  // Next raster position and the sync/blank levels that belong to it
  always_comb begin
    x_wrap     = (DrawX == H_LAST);
    y_wrap     = (DrawY == V_LAST);
    frame_wrap = x_wrap && y_wrap;
    x_next     = x_wrap ? 10'd0 : DrawX + 10'd1;
    y_next     = DrawY;
    if (x_wrap) begin
      y_next = y_wrap ? 10'd0 : DrawY + 10'd1;
    end
    hs_next    = !((x_next >= HS_START) && (x_next <= HS_END));
    vs_next    = !((y_next >= VS_START) && (y_next <= VS_END));
    blank_next = (x_next < H_VIS) && (y_next < V_VIS);
  end

  // Raster counters advance only on pixel-enable cycles
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      DrawX <= 10'd0;
      DrawY <= 10'd0;
    end else if (pix_en) begin
      DrawX <= x_next;
      DrawY <= y_next;
    end
  end

  // Frame pulse is a single vga_clk wide; the count wraps naturally at 16 bits
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_start <= 1'b0;
      frame_count <= 16'd0;
    end else begin
      frame_start <= pix_en && frame_wrap;
      if (pix_en && frame_wrap) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  logic hs_d1;
  logic vs_d1;
  logic blank_d1;
  logic hs_d2;
  logic vs_d2;
  logic blank_d2;

  // Sync/blank lag the raster position by two pixel advances to match pixel data latency
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_d1    <= 1'b1;
      vs_d1    <= 1'b1;
      blank_d1 <= 1'b0;
      hs_d2    <= 1'b1;
      vs_d2    <= 1'b1;
      blank_d2 <= 1'b0;
      hs       <= 1'b1;
      vs       <= 1'b1;
      blank    <= 1'b0;
    end else if (pix_en) begin
      hs_d1    <= hs_next;
      vs_d1    <= vs_next;
      blank_d1 <= blank_next;
      hs_d2    <= hs_d1;
      vs_d2    <= vs_d1;
      blank_d2 <= blank_d1;
      hs       <= hs_d2;
      vs       <= vs_d2;
      blank    <= blank_d2;
    end
  end
`else
  // Sync/blank registered from the next position so they line up with DrawX/DrawY
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hs    <= 1'b1;
      vs    <= 1'b1;
      blank <= 1'b0;
    end else if (pix_en) begin
      hs    <= hs_next;
      vs    <= vs_next;
      blank <= blank_next;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

  localparam int HV = 8;
  localparam int HF = 2;
  localparam int HSW = 3;
  localparam int HB = 2;
  localparam int VV = 5;
  localparam int VF = 1;
  localparam int VSW = 2;
  localparam int VB = 1;
  localparam int HT = HV + HF + HSW + HB;
  localparam int VT = VV + VF + VSW + VB;
  localparam int FT = HT * VT;
`ifdef VGA_SYNC_DELAY_EN
  localparam int LAG = 2;
`else
  localparam int LAG = 0;
`endif

  logic        vga_clk;
  logic        reset_n;
  logic        pix_en;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        hs;
  logic        vs;
  logic        blank;
  logic        frame_start;
  logic [15:0] frame_count;

  int checks = 0;
  int errors = 0;
  int n = 0;
  int base = 0;
  bit adv = 0;
  logic [15:0] prev_count;
  int wraps_seen = 0;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB)
  ) dut (
    .vga_clk(vga_clk),
    .reset_n(reset_n),
    .pix_en(pix_en),
    .DrawX(DrawX),
    .DrawY(DrawY),
    .hs(hs),
    .vs(vs),
    .blank(blank),
    .frame_start(frame_start),
    .frame_count(frame_count)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (advances=%0d)", tag, obs, exp, n);
    end
  endtask

  // Reference: position is pure arithmetic on the number of pixel advances since reset
  task automatic check_all();
    int x, y, m, sx, sy;
    logic e_hs, e_vs, e_blank, e_fs;
    logic [15:0] e_fc;
    x = n % HT;
    y = (n / HT) % VT;
    m = n - LAG;
    if (m >= 1) begin
      sx = m % HT;
      sy = (m / HT) % VT;
      e_hs    = !(sx >= HV + HF && sx < HV + HF + HSW);
      e_vs    = !(sy >= VV + VF && sy < VV + VF + VSW);
      e_blank = (sx < HV) && (sy < VV);
    end else begin
      e_hs = 1'b1;
      e_vs = 1'b1;
      e_blank = 1'b0;
    end
    e_fs = adv && (n > 0) && (n % FT == 0);
    e_fc = 16'((base + n / FT) & 32'hFFFF);
    chk("DrawX", 32'(DrawX), 32'(x));
    chk("DrawY", 32'(DrawY), 32'(y));
    chk("hs", 32'(hs), 32'(e_hs));
    chk("vs", 32'(vs), 32'(e_vs));
    chk("blank", 32'(blank), 32'(e_blank));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
    chk("frame_count", 32'(frame_count), 32'(e_fc));
    if (e_fs && e_fc == 16'd0 && base != 0) begin
      chk("fc_before_wrap", 32'(prev_count), 32'hFFFF);
      wraps_seen++;
    end
    prev_count = frame_count;
  endtask

  task automatic step(input bit en);
    pix_en = en;
    @(posedge vga_clk);
    if (en) n++;
    adv = en;
    @(negedge vga_clk);
    check_all();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_DrawX"}, 32'(DrawX), 0);
    chk({tag, "_DrawY"}, 32'(DrawY), 0);
    chk({tag, "_hs"}, 32'(hs), 1);
    chk({tag, "_vs"}, 32'(vs), 1);
    chk({tag, "_blank"}, 32'(blank), 0);
    chk({tag, "_frame_start"}, 32'(frame_start), 0);
    chk({tag, "_frame_count"}, 32'(frame_count), 0);
  endtask

  initial begin
    reset_n = 1'b0;
    pix_en = 1'b0;
    prev_count = 16'd0;
    repeat (3) @(posedge vga_clk);
    @(negedge vga_clk);
    check_reset_vals("reset");
    reset_n = 1'b1;

    // continuous enable: several full frames
    for (int i = 0; i < 3 * FT + 7; i++) step(1'b1);
    // alternating enable
    for (int i = 0; i < 2 * FT + 10; i++) step(i % 2 == 0);
    // random enable
    for (int i = 0; i < 1200; i++) step(1'(($urandom % 4) != 0));

    // run to a mid-frame position, then reset asynchronously
    while ((n % FT) != 3 * HT + 5) step(1'b1);
    #1 reset_n = 1'b0;
    #1 check_reset_vals("async_reset");
    @(posedge vga_clk);
    @(negedge vga_clk);
    check_reset_vals("reset_hold");
    reset_n = 1'b1;
    n = 0;
    adv = 0;
    base = 0;
    prev_count = 16'd0;
    step(1'b1);
    chk("post_reset_DrawX", 32'(DrawX), 1);
    for (int i = 0; i < FT; i++) step(1'(($urandom % 3) != 0));

    // preload the frame counter near its wrap and run through it
    force dut.frame_count = 16'hFFFE;
    #1 release dut.frame_count;
    base = 65534 - n / FT;
    prev_count = 16'hFFFE;
    for (int i = 0; i < 2 * FT + 20; i++) step(1'b1);
    for (int i = 0; i < FT; i++) step(1'(($urandom % 2) != 0));
    chk("wrap_seen", 32'(wraps_seen), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
